// File: rtl/zion_riscv_isa_lib_bits_dec_stage.sv
// Bit-op decode/issue stage: decodes AND/OR/XOR (+I forms) into a 2-entry skid buffer.
// Optional LUI decode (as OR with zero) under ZION_RISCV_ISA_LIB_BITS_DEC_LUI_EN.
module zion_riscv_isa_lib_bits_dec_stage #(
    parameter  int unsigned RV64      = 0,
    localparam int unsigned CPU_WIDTH = 32 * (RV64 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iFlush,
    input  logic                 iInstVld,
    output logic                 oInstRdy,
    input  logic [31:0]          iInst,
    input  logic [CPU_WIDTH-1:0] iRs1Dat,
    input  logic [CPU_WIDTH-1:0] iRs2Dat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic                 oAndEn,
    output logic                 oOrEn,
    output logic                 oXorEn,
    output logic [CPU_WIDTH-1:0] oS1,
    output logic [CPU_WIDTH-1:0] oS2,
    output logic [4:0]           oRdIdx,
    output logic                 oUnsup,
    output logic [15:0]          oUnsupCnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    typedef struct packed {
        logic                 and_en;
        logic                 or_en;
        logic                 xor_en;
        logic [4:0]           rd;
        logic [CPU_WIDTH-1:0] s1;
        logic [CPU_WIDTH-1:0] s2;
    } entry_t;

    occ_t                 occ_q, occ_d;
    entry_t               main_q, main_d, skid_q, skid_d, new_entry;
    logic                 vld_q, rdy_q, unsup_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           sel;
    logic [CPU_WIDTH-1:0] dec_s1, dec_s2, imm_i;
    logic                 dec_ok, accept, push, pop, unsup_acc;
    logic                 unused_rs_fields;

    // funct3 -> {and, or, xor} one-hot; zero for anything else
    function automatic logic [2:0] f3_sel(input logic [2:0] f3);
        case (f3)
            3'b111:  return 3'b100;
            3'b110:  return 3'b010;
            3'b100:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign imm_i            = CPU_WIDTH'($signed(iInst[31:20]));
    assign unused_rs_fields = ^iInst[19:15];

    always_comb begin
        sel    = 3'b000;
        dec_s1 = iRs1Dat;
        dec_s2 = iRs2Dat;
        case (iInst[6:0])
            OPC_OP: begin
                if (iInst[31:25] == 7'b0000000) sel = f3_sel(iInst[14:12]);
            end
            OPC_OP_IMM: begin
                sel    = f3_sel(iInst[14:12]);
                dec_s2 = imm_i;
            end
`ifdef ZION_RISCV_ISA_LIB_BITS_DEC_LUI_EN
            OPC_LUI: begin
                sel    = 3'b010;
                dec_s1 = '0;
                dec_s2 = CPU_WIDTH'($signed({iInst[31:12], 12'h000}));
            end
`endif
            default: sel = 3'b000;
        endcase
    end

    assign dec_ok    = |sel;
    assign accept    = iInstVld & rdy_q;
    assign push      = accept & dec_ok;
    assign unsup_acc = accept & ~dec_ok;
    assign pop       = vld_q & iRdy;
    assign new_entry = '{and_en: sel[2], or_en: sel[1], xor_en: sel[0],
                         rd: iInst[11:7], s1: dec_s1, s2: dec_s2};

    // Occupancy next-state and buffer moves
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    occ_d  = ONE;
                    main_d = new_entry;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_d = new_entry;
                end else if (push) begin
                    occ_d  = TWO;
                    skid_d = new_entry;
                end else if (pop) begin
                    occ_d  = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    occ_d  = ONE;
                    main_d = skid_q;
                end
            end
            default: occ_d = EMPTY;
        endcase
        if (iFlush) occ_d = EMPTY;
        // Enables must read all-zero whenever nothing is presented
        if (occ_d == EMPTY) begin
            main_d.and_en = 1'b0;
            main_d.or_en  = 1'b0;
            main_d.xor_en = 1'b0;
        end
    end

    assign cnt_d = (unsup_acc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            unsup_q <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            occ_q   <= occ_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            vld_q   <= (occ_d != EMPTY);
            rdy_q   <= (occ_d != TWO);
            unsup_q <= unsup_acc;
            cnt_q   <= cnt_d;
        end
    end

    assign oInstRdy  = rdy_q;
    assign oVld      = vld_q;
    assign oAndEn    = main_q.and_en;
    assign oOrEn     = main_q.or_en;
    assign oXorEn    = main_q.xor_en;
    assign oS1       = main_q.s1;
    assign oS2       = main_q.s2;
    assign oRdIdx    = main_q.rd;
    assign oUnsup    = unsup_q;
    assign oUnsupCnt = cnt_q;

endmodule

// File: tb/tb_zion_riscv_isa_lib_bits_dec_stage.sv
// Directed bench for the bit-op decode stage (RV64 build); LUI expectations follow
// ZION_RISCV_ISA_LIB_BITS_DEC_LUI_EN.
module tb_zion_riscv_isa_lib_bits_dec_stage;

    localparam int unsigned W = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          iFlush, iInstVld, oInstRdy, oVld, iRdy;
    logic          oAndEn, oOrEn, oXorEn, oUnsup;
    logic [31:0]   iInst;
    logic [W-1:0]  iRs1Dat, iRs2Dat, oS1, oS2;
    logic [4:0]    oRdIdx;
    logic [15:0]   oUnsupCnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_cnt;

    zion_riscv_isa_lib_bits_dec_stage #(.RV64(1)) dut (
        .clk(clk), .rst(rst), .iFlush(iFlush), .iInstVld(iInstVld), .oInstRdy(oInstRdy),
        .iInst(iInst), .iRs1Dat(iRs1Dat), .iRs2Dat(iRs2Dat), .oVld(oVld), .iRdy(iRdy),
        .oAndEn(oAndEn), .oOrEn(oOrEn), .oXorEn(oXorEn), .oS1(oS1), .oS2(oS2),
        .oRdIdx(oRdIdx), .oUnsup(oUnsup), .oUnsupCnt(oUnsupCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    task automatic push_or(input logic [4:0] rd);
        iInstVld = 1'b1;
        iInst    = enc_r(7'd0, 3'b110, rd);
        iRs1Dat  = 64'h100 + 64'(rd);
    endtask

    task automatic chk_ops(input string tag, input logic a, input logic o, input logic x);
        chk({tag, "_and"}, 64'(oAndEn), 64'(a));
        chk({tag, "_or"},  64'(oOrEn),  64'(o));
        chk({tag, "_xor"}, 64'(oXorEn), 64'(x));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"}, 64'(oVld), 64'd0);
        chk({tag, "_rdy"}, 64'(oInstRdy), 64'd1);
        chk_ops(tag, 1'b0, 1'b0, 1'b0);
        chk({tag, "_s1"}, oS1, 64'd0);
        chk({tag, "_s2"}, oS2, 64'd0);
        chk({tag, "_rd"}, 64'(oRdIdx), 64'd0);
        chk({tag, "_unsup"}, 64'(oUnsup), 64'd0);
        chk({tag, "_cnt"}, 64'(oUnsupCnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1; iFlush = 1'b0; iInstVld = 1'b0; iRdy = 1'b1;
        iInst = 32'h0; iRs1Dat = '0; iRs2Dat = '0;
        exp_cnt = 16'd0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Single AND, popped immediately
        iInstVld = 1'b1;
        iInst    = enc_r(7'd0, 3'b111, 5'd3);
        iRs1Dat  = 64'hF0F0_F0F0;
        iRs2Dat  = 64'hFF00_FF00;
        tick();
        iInstVld = 1'b0;
        chk("and_vld", 64'(oVld), 64'd1);
        chk_ops("and", 1'b1, 1'b0, 1'b0);
        chk("and_s1", oS1, 64'hF0F0_F0F0);
        chk("and_s2", oS2, 64'hFF00_FF00);
        chk("and_rd", 64'(oRdIdx), 64'd3);
        chk("and_rdy", 64'(oInstRdy), 64'd1);
        tick();
        chk("and_drain_vld", 64'(oVld), 64'd0);
        chk_ops("and_drain", 1'b0, 1'b0, 1'b0);

        // XORI with negative immediate
        iInstVld = 1'b1;
        iInst    = enc_i(12'h800, 3'b100, 5'd5);
        iRs1Dat  = 64'h1234_5678_9ABC_DEF0;
        tick();
        iInstVld = 1'b0;
        chk("xori_vld", 64'(oVld), 64'd1);
        chk_ops("xori", 1'b0, 1'b0, 1'b1);
        chk("xori_s1", oS1, 64'h1234_5678_9ABC_DEF0);
        chk("xori_s2", oS2, 64'hFFFF_FFFF_FFFF_F800);
        chk("xori_rd", 64'(oRdIdx), 64'd5);
        tick();

        // Back-pressure: three ORs against a stalled consumer
        iRdy = 1'b0;
        push_or(5'd7);
        tick();
        chk("bp1_rdy", 64'(oInstRdy), 64'd1);
        chk("bp1_rd", 64'(oRdIdx), 64'd7);
        push_or(5'd8);
        tick();
        chk("bp2_rdy", 64'(oInstRdy), 64'd0);
        chk("bp2_rd", 64'(oRdIdx), 64'd7);
        push_or(5'd9);
        tick();
        chk("bp3_rdy", 64'(oInstRdy), 64'd0);
        chk("bp3_rd_stable", 64'(oRdIdx), 64'd7);
        chk("bp3_s1_stable", oS1, 64'h107);
        chk_ops("bp3", 1'b0, 1'b1, 1'b0);
        iRdy = 1'b1;
        tick();
        chk("bp4_rd", 64'(oRdIdx), 64'd8);
        chk("bp4_s1", oS1, 64'h108);
        chk("bp4_rdy", 64'(oInstRdy), 64'd1);
        tick();
        iInstVld = 1'b0;
        chk("bp5_rd", 64'(oRdIdx), 64'd9);
        chk("bp5_vld", 64'(oVld), 64'd1);
        tick();
        chk("bp6_vld", 64'(oVld), 64'd0);

        // Unsupported: ADD and OP with funct7 0100000
        iInstVld = 1'b1;
        iInst    = enc_r(7'd0, 3'b000, 5'd4);
        tick();
        exp_cnt++;
        chk("add_unsup", 64'(oUnsup), 64'd1);
        chk("add_vld", 64'(oVld), 64'd0);
        chk("add_cnt", 64'(oUnsupCnt), 64'(exp_cnt));
        iInst = enc_r(7'b0100000, 3'b111, 5'd4);
        tick();
        exp_cnt++;
        iInstVld = 1'b0;
        chk("f7_unsup", 64'(oUnsup), 64'd1);
        chk("f7_vld", 64'(oVld), 64'd0);
        chk("f7_cnt", 64'(oUnsupCnt), 64'd2);
        tick();
        chk("unsup_pulse_end", 64'(oUnsup), 64'd0);

        // LUI
        iInstVld = 1'b1;
        iInst    = {20'h12345, 5'd10, 7'b0110111};
        iRs1Dat  = 64'hDEAD;
        tick();
        iInstVld = 1'b0;
`ifdef ZION_RISCV_ISA_LIB_BITS_DEC_LUI_EN
        chk("lui_vld", 64'(oVld), 64'd1);
        chk_ops("lui", 1'b0, 1'b1, 1'b0);
        chk("lui_s1", oS1, 64'd0);
        chk("lui_s2", oS2, 64'h1234_5000);
        chk("lui_unsup", 64'(oUnsup), 64'd0);
`else
        exp_cnt++;
        chk("lui_vld", 64'(oVld), 64'd0);
        chk("lui_unsup", 64'(oUnsup), 64'd1);
`endif
        chk("lui_cnt", 64'(oUnsupCnt), 64'(exp_cnt));
        tick();

        // Flush from TWO with upstream still presenting
        iRdy = 1'b0;
        push_or(5'd11);
        tick();
        push_or(5'd12);
        tick();
        chk("fl_two_rdy", 64'(oInstRdy), 64'd0);
        push_or(5'd13);
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        iInstVld = 1'b0;
        chk("fl_two_vld", 64'(oVld), 64'd0);
        chk("fl_two_rdy2", 64'(oInstRdy), 64'd1);
        chk_ops("fl_two", 1'b0, 1'b0, 1'b0);
        tick();
        chk("fl_two_absent", 64'(oVld), 64'd0);

        // Flush from ONE overriding an accepted push
        push_or(5'd14);
        tick();
        push_or(5'd15);
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        iInstVld = 1'b0;
        chk("fl_one_vld", 64'(oVld), 64'd0);
        tick();
        chk("fl_one_absent", 64'(oVld), 64'd0);

        // Unsupported accepted during flush is still counted
        push_or(5'd16);
        tick();
        iInst  = enc_r(7'd0, 3'b000, 5'd1);
        iFlush = 1'b1;
        tick();
        exp_cnt++;
        iFlush = 1'b0;
        iInstVld = 1'b0;
        chk("fl_unsup_vld", 64'(oVld), 64'd0);
        chk("fl_unsup_pulse", 64'(oUnsup), 64'd1);
        chk("fl_unsup_cnt", 64'(oUnsupCnt), 64'(exp_cnt));

        // Async reset mid-stream
        push_or(5'd17);
        iRs2Dat = 64'h55;
        tick();
        push_or(5'd18);
        tick();
        chk("pre_rst_vld", 64'(oVld), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        iInstVld = 1'b0;
        tick();
        rst = 1'b0;
        iRdy = 1'b1;
        exp_cnt = 16'd0;
        tick();

        // Counter saturation
        iInstVld = 1'b1;
        iInst    = enc_r(7'd0, 3'b000, 5'd2);
        for (int i = 0; i < 65535; i++) tick();
        chk("sat_cnt_max", 64'(oUnsupCnt), 64'hFFFF);
        tick();
        tick();
        iInstVld = 1'b0;
        chk("sat_cnt_hold", 64'(oUnsupCnt), 64'hFFFF);
        chk("sat_pulse", 64'(oUnsup), 64'd1);
        chk("sat_vld", 64'(oVld), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
